rtc_core: RTL
=============

RTC_CORE -- requirements
Module: rtc_core

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, time-advance rate in Hz; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-003 SHALL have parameter RING_SECS, default 10, alarm ring duration in ticks (1..59).
REQ-004 clk_100MHz  in  1  system clock; all state SHALL be in this single domain.
REQ-005 reset_1  in  1  asynchronous, active-high reset.
REQ-006 set_mode  in  1  level; 1 = time halted, buttons edit time; 0 = run.
REQ-007 inc_sec, inc_min, inc_hour  in  1 each  raw asynchronous push buttons.
REQ-008 fmt12  in  1  display format; 0 = 24 h, 1 = 12 h.
REQ-009 tick  out  1  one-cycle pulse at each time advance.
REQ-010 sec_tens, sec_ones, min_tens, min_ones, hour_tens, hour_ones  out  4 each  BCD display digits.
REQ-011 pm  out  1  1 when internal hour >= 12, in both formats.
REQ-012 Under RTC_ALARM_EN only: alarm_set in 1, alarm_arm in 1, ring out 1, alm_hour_tens/alm_hour_ones/alm_min_tens/alm_min_ones out 4 each (always 24 h BCD).

Function
REQ-013 Each button SHALL pass a 2-flop synchroniser, then a rising-edge detector; one press = one 1-cycle pulse, 3-cycle latency from the pin.
REQ-014 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1; tick SHALL pulse in the cycle the count wraps to 0.
REQ-015 In set_mode=1 the prescaler SHALL be held at 0 and tick SHALL stay 0; on return to 0 the first tick SHALL occur exactly CLK_HZ/TICK_HZ cycles later.
REQ-016 Time SHALL be held as BCD digit counters (no divide/modulo); hours internal 00..23.
REQ-017 On tick: sec +1; 59->00 carries min +1; min 59->00 carries hour +1; 23:59:59 -> 00:00:00.
REQ-018 In set_mode=1 an inc_sec/inc_min/inc_hour pulse SHALL advance only that field by 1, wrapping 59->00 / 23->00 with no carry.
REQ-019 Button pulses in set_mode=0 SHALL be ignored.
REQ-020 Simultaneous pulses on several buttons SHALL each apply to their own field in the same cycle.
REQ-021 Outputs SHALL be registered and update the cycle after the counter change.
REQ-022 fmt12=1: internal 0 -> 12, 1..12 -> 1..12, 13..23 -> 1..11; hour_tens shows 0 (not blank) for 1..9; fmt12 change SHALL take effect next cycle without altering time.

Reset
REQ-023 reset_1 SHALL clear prescaler, synchroniser and edge registers, and all time digits to 00:00:00; tick=0, pm=0, ring=0.
REQ-024 Under RTC_ALARM_EN the alarm SHALL reset to 00:00, disarmed ring counter 0.
REQ-025 Reset asserted mid-count SHALL take effect immediately; first tick after release SHALL come CLK_HZ/TICK_HZ cycles after release.

Configuration
REQ-026 Macro RTC_ALARM_EN: when defined, alarm registers, ring logic and REQ-012 ports SHALL exist; when undefined they SHALL be absent and REQ-001..011 behaviour SHALL be unchanged.
REQ-027 With RTC_ALARM_EN, alarm_set=1 and set_mode=1: inc_min/inc_hour SHALL edit the alarm instead of time, inc_sec ignored.
REQ-028 ring SHALL assert on the tick that makes time equal alarm hh:mm:00 when alarm_arm=1, and deassert after RING_SECS ticks, on any button pulse, or when alarm_arm falls.

Structure
REQ-029 Package rtc_pkg SHALL hold BCD digit typedef, limit constants (59, 23, 12) and the prescaler-width function clog2(CLK_HZ/TICK_HZ).
REQ-030 Prescaler SHALL be sub-module rtc_tick_gen (params CLK_HZ, TICK_HZ; ports clk, reset, hold, tick).

Verification (CLK_HZ=10, TICK_HZ=1)
REQ-031 Reset release, run 600 cycles -> tick every 10 cycles, display 00:01:00 after 60 ticks.
REQ-032 Preload 23:59:58 via set_mode, run 2 ticks -> 00:00:00, pm=0.
REQ-033 set_mode=1, min=59, one inc_min press -> min 00, hour unchanged, no tick.
REQ-034 Time 13:05:00, fmt12=1 -> hour digits 0,1, pm=1; fmt12=0 -> 1,3.
REQ-035 Alarm 00:01, armed, from 00:00:58 -> ring rises on tick to 00:01:00, falls after 3 ticks (RING_SECS=3) or on inc_sec press.
REQ-036 reset_1 pulsed at prescaler count 5 -> all digits 00, next tick 10 cycles after release.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared BCD types, field limits and helpers for the real-time clock
package rtc_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] bcd2_t;

    // Bit positions of the three push buttons in the button vectors
    typedef enum logic [1:0] {
        F_SEC  = 2'd0,
        F_MIN  = 2'd1,
        F_HOUR = 2'd2
    } field_e;

    // Two-digit BCD limits; BCD ordering matches numeric ordering
    localparam bcd2_t SEC_LIM  = 8'h59;
    localparam bcd2_t HOUR_LIM = 8'h23;
    localparam bcd2_t NOON     = 8'h12;

    function automatic int presc_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Two-digit BCD increment that wraps lim -> 00, using only digit arithmetic
    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t lim);
        return (v == lim) ? 8'h00 :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/rtc_tick_gen.sv
// rtc_tick_gen: prescaler producing one tick per CLK_HZ/TICK_HZ cycles, held at 0 while hold
module rtc_tick_gen
    import rtc_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int W   = presc_width(DIV);

    logic [W-1:0] cnt;

    // Count 0..DIV-1; tick is high in the cycle the count has just wrapped to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (hold) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == W'(DIV - 1)) ? '0 : cnt + 1'b1;
            tick <= (cnt == W'(DIV - 1));
        end
    end

endmodule

// File: rtl/rtc_core.sv
// rtc_core: BCD real-time clock with set mode and 12/24 h display; alarm under RTC_ALARM_EN
module rtc_core
    import rtc_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1,
    parameter int RING_SECS = 10
) (
    input  logic clk_100MHz,
    input  logic reset_1,
    input  logic set_mode,
    input  logic inc_sec,
    input  logic inc_min,
    input  logic inc_hour,
    input  logic fmt12,
    output logic tick,
    output bcd_t sec_tens,
    output bcd_t sec_ones,
    output bcd_t min_tens,
    output bcd_t min_ones,
    output bcd_t hour_tens,
    output bcd_t hour_ones,
    output logic pm
`ifdef RTC_ALARM_EN
    ,
    input  logic alarm_set,
    input  logic alarm_arm,
    output logic ring,
    output bcd_t alm_hour_tens,
    output bcd_t alm_hour_ones,
    output bcd_t alm_min_tens,
    output bcd_t alm_min_ones
`endif
);

    if (CLK_HZ / TICK_HZ < 2 || RING_SECS < 1 || RING_SECS > 59) begin : g_bad_cfg
        $error("rtc_core: invalid CLK_HZ/TICK_HZ or RING_SECS");
    end

    logic [2:0] btn, s1, s2, s3, press;
    bcd2_t      cur_sec, cur_min, cur_hour;
    bcd2_t      sec_n, min_n, hour_n, hour12;
    logic       edit_time;

    assign btn = {inc_hour, inc_min, inc_sec};

    rtc_tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk   (clk_100MHz),
        .reset (reset_1),
        .hold  (set_mode),
        .tick  (tick)
    );

    // Two-flop synchroniser plus registered rising-edge detector per button
    always_ff @(posedge clk_100MHz or posedge reset_1) begin
        if (reset_1) begin
            s1    <= '0;
            s2    <= '0;
            s3    <= '0;
            press <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            s3    <= s2;
            press <= s2 & ~s3;
        end
    end

    // Next time on a tick, with seconds->minutes->hours carries, plus the 12 h view of the hour
    always_comb begin
        sec_n  = bcd_inc(cur_sec, SEC_LIM);
        min_n  = (cur_sec == SEC_LIM) ? bcd_inc(cur_min, SEC_LIM) : cur_min;
        hour_n = (cur_sec == SEC_LIM && cur_min == SEC_LIM) ? bcd_inc(cur_hour, HOUR_LIM) : cur_hour;
        hour12 = (cur_hour == 8'h00) ? NOON :
                 (cur_hour <= NOON) ? cur_hour :
                 (cur_hour[3:0] >= 4'd2) ? {cur_hour[7:4] - 4'd1, cur_hour[3:0] - 4'd2}
                                         : {cur_hour[7:4] - 4'd2, cur_hour[3:0] + 4'd8};
    end

`ifdef RTC_ALARM_EN
    assign edit_time = set_mode & ~alarm_set;
`else
    assign edit_time = set_mode;
`endif

    // Time counters: advance on tick, or edit individual fields without carry in set mode
    always_ff @(posedge clk_100MHz or posedge reset_1) begin
        if (reset_1) begin
            cur_sec  <= '0;
            cur_min  <= '0;
            cur_hour <= '0;
        end else if (tick) begin
            cur_sec  <= sec_n;
            cur_min  <= min_n;
            cur_hour <= hour_n;
        end else if (edit_time) begin
            if (press[F_SEC])  cur_sec  <= bcd_inc(cur_sec, SEC_LIM);
            if (press[F_MIN])  cur_min  <= bcd_inc(cur_min, SEC_LIM);
            if (press[F_HOUR]) cur_hour <= bcd_inc(cur_hour, HOUR_LIM);
        end
    end

    // Registered display digits, one cycle behind the counters
    always_ff @(posedge clk_100MHz or posedge reset_1) begin
        if (reset_1) begin
            {sec_tens, sec_ones}   <= '0;
            {min_tens, min_ones}   <= '0;
            {hour_tens, hour_ones} <= '0;
            pm                     <= 1'b0;
        end else begin
            {sec_tens, sec_ones}   <= cur_sec;
            {min_tens, min_ones}   <= cur_min;
            {hour_tens, hour_ones} <= fmt12 ? hour12 : cur_hour;
            pm                     <= (cur_hour >= NOON);
        end
    end

`ifdef RTC_ALARM_EN
    bcd2_t      alm_h, alm_m;
    logic [5:0] ring_cnt;

    assign {alm_hour_tens, alm_hour_ones} = alm_h;
    assign {alm_min_tens, alm_min_ones}   = alm_m;

    // Alarm editing and ring control; any clearing condition beats a new match
    always_ff @(posedge clk_100MHz or posedge reset_1) begin
        if (reset_1) begin
            alm_h    <= '0;
            alm_m    <= '0;
            ring     <= 1'b0;
            ring_cnt <= '0;
        end else begin
            if (set_mode && alarm_set && press[F_MIN])  alm_m <= bcd_inc(alm_m, SEC_LIM);
            if (set_mode && alarm_set && press[F_HOUR]) alm_h <= bcd_inc(alm_h, HOUR_LIM);
            if (!alarm_arm || |press) begin
                ring <= 1'b0;
            end else if (tick && cur_sec == SEC_LIM && min_n == alm_m && hour_n == alm_h) begin
                ring     <= 1'b1;
                ring_cnt <= '0;
            end else if (tick && ring) begin
                if (ring_cnt == 6'(RING_SECS - 1)) ring <= 1'b0;
                ring_cnt <= ring_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
